// File: rtl/alu_shift_sequencer.sv
// rtl/alu_shift_sequencer.sv - iterates a single-step ALU shift/rotate op up to 255 times.
// Optional macro SHIFT_COUNT_MASK_EN masks the count to its low 5 bits.
`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 5
`endif

module alu_shift_sequencer (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [`MC_ALUOp_t_BITS-1:0]   op_in,
  input  logic                          is_8_bit_in,
  input  logic [15:0]                   operand,
  input  logic [7:0]                    count,
  input  logic [15:0]                   flags_in,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   result,
  output logic [15:0]                   flags_result,
  output logic [15:0]                   alu_a,
  output logic [15:0]                   alu_b,
  output logic [15:0]                   alu_flags_in,
  output logic [`MC_ALUOp_t_BITS-1:0]   alu_op,
  output logic                          alu_is_8_bit,
  input  logic [15:0]                   alu_out,
  input  logic [15:0]                   alu_flags_out
);

  localparam int OPW = `MC_ALUOp_t_BITS;

  localparam logic [OPW-1:0] ALUOp_SELA = OPW'(0);
  localparam logic [OPW-1:0] ALUOp_SHL  = OPW'(10);
  localparam logic [OPW-1:0] ALUOp_SHR  = OPW'(11);
  localparam logic [OPW-1:0] ALUOp_SAR  = OPW'(12);
  localparam logic [OPW-1:0] ALUOp_ROL  = OPW'(13);
  localparam logic [OPW-1:0] ALUOp_ROR  = OPW'(14);
  localparam logic [OPW-1:0] ALUOp_RCL  = OPW'(15);
  localparam logic [OPW-1:0] ALUOp_RCR  = OPW'(16);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [15:0]    acc;
  logic [15:0]    flg;
  logic [7:0]     remaining;
  logic [7:0]     cnt_q;
  logic [OPW-1:0] op_q;
  logic           is_8_bit_q;
  logic           shift_q;
  logic           shift_in;
  logic [7:0]     eff_count;
  logic [7:0]     start_iters;

  function automatic logic is_shift_op(input logic [OPW-1:0] op);
    case (op)
      ALUOp_SHL, ALUOp_SHR, ALUOp_SAR, ALUOp_ROL,
      ALUOp_ROR, ALUOp_RCL, ALUOp_RCR: is_shift_op = 1'b1;
      default:                         is_shift_op = 1'b0;
    endcase
  endfunction

`ifdef SHIFT_COUNT_MASK_EN
  assign eff_count = count & 8'h1F;
`else
  assign eff_count = count;
`endif

  // Non-shift ops always take one pass, with the raw count as the B operand.
  assign shift_in    = is_shift_op(op_in);
  assign start_iters = shift_in ? eff_count : 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (start_iters != 8'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (remaining == 8'd1) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= 16'h0000;
      flg        <= 16'h0000;
      remaining  <= 8'd0;
      cnt_q      <= 8'd0;
      op_q       <= ALUOp_SELA;
      is_8_bit_q <= 1'b0;
      shift_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc        <= operand;
            flg        <= flags_in;
            remaining  <= start_iters;
            cnt_q      <= count;
            op_q       <= op_in;
            is_8_bit_q <= is_8_bit_in;
            shift_q    <= shift_in;
          end
        end
        RUN: begin
          acc       <= alu_out;
          flg       <= alu_flags_out;
          remaining <= remaining - 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    result       = done ? acc : 16'h0000;
    flags_result = done ? flg : 16'h0000;
    alu_op       = ALUOp_SELA;
    alu_a        = acc;
    alu_b        = 16'h0000;
    alu_flags_in = flg;
    alu_is_8_bit = is_8_bit_q;
    if (state_q == RUN) begin
      alu_op = op_q;
      alu_b  = shift_q ? 16'h0001 : {8'h00, cnt_q};
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb/tb_alu_shift_sequencer.sv - scoreboard bench for alu_shift_sequencer with a behavioural one-step ALU.
`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 5
`endif

module tb_alu_shift_sequencer;

  localparam int OPW = `MC_ALUOp_t_BITS;
  localparam logic [OPW-1:0] OP_SELA = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(10);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(11);
  localparam logic [OPW-1:0] OP_SAR  = OPW'(12);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(13);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(14);
  localparam logic [OPW-1:0] OP_RCL  = OPW'(15);

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [OPW-1:0] op_in = OP_SELA;
  logic           is_8_bit_in = 1'b0;
  logic [15:0]    operand = 16'h0000;
  logic [7:0]     count = 8'd0;
  logic [15:0]    flags_in = 16'h0000;
  logic           busy, done;
  logic [15:0]    result, flags_result, alu_a, alu_b, alu_flags_in;
  logic [OPW-1:0] alu_op;
  logic           alu_is_8_bit;
  logic [15:0]    alu_out, alu_flags_out;

  alu_shift_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_in(op_in),
    .is_8_bit_in(is_8_bit_in), .operand(operand), .count(count), .flags_in(flags_in),
    .busy(busy), .done(done), .result(result), .flags_result(flags_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_flags_in(alu_flags_in), .alu_op(alu_op),
    .alu_is_8_bit(alu_is_8_bit), .alu_out(alu_out), .alu_flags_out(alu_flags_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: one-bit shifts/rotates, CF in FLAGS bit 0; ADD for the non-shift path.
  always_comb begin
    logic [15:0] x;
    logic [15:0] mask;
    int          msb;
    logic        cin;
    msb  = alu_is_8_bit ? 7 : 15;
    mask = alu_is_8_bit ? 16'h00FF : 16'hFFFF;
    x    = alu_a & mask;
    cin  = alu_flags_in[0];
    alu_out       = alu_a;
    alu_flags_out = alu_flags_in;
    case (alu_op)
      OP_ADD: begin
        {alu_flags_out[0], alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      end
      OP_SHL: begin alu_flags_out[0] = x[msb]; alu_out = (x << 1) & mask; end
      OP_SHR: begin alu_flags_out[0] = x[0];   alu_out = x >> 1; end
      OP_SAR: begin alu_flags_out[0] = x[0];   alu_out = (x >> 1) | (16'(x[msb]) << msb); end
      OP_ROL: begin alu_flags_out[0] = x[msb]; alu_out = ((x << 1) | 16'(x[msb])) & mask; end
      OP_ROR: begin alu_flags_out[0] = x[0];   alu_out = (x >> 1) | (16'(x[0]) << msb); end
      OP_RCL: begin alu_flags_out[0] = x[msb]; alu_out = ((x << 1) | 16'(cin)) & mask; end
      default: begin end
    endcase
  end

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [15:0] flg;
    int          lat;
    int          c0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, 32'(result), 32'(e.res));
        check({e.name, "_flags"}, 32'(flags_result), 32'(e.flg));
        check({e.name, "_latency"}, 32'(cyc - e.c0), 32'(e.lat));
      end
    end
  end

  task automatic issue(input string name, input logic [OPW-1:0] op, input logic is8,
                       input logic [15:0] opnd, input logic [7:0] cnt, input logic [15:0] fl,
                       input logic [15:0] er, input logic [15:0] ef, input int lat, input int hold);
    exp_t e;
    @(negedge clk);
    op_in = op; is_8_bit_in = is8; operand = opnd; count = cnt; flags_in = fl;
    start = 1'b1;
    e.name = name; e.res = er; e.flg = ef; e.lat = lat; e.c0 = cyc;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    check({name, "_timeout"}, 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags_result), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'(OP_SELA));
    check("rst_alu_b", 32'(alu_b), 32'd0);
    reset_n = 1'b1;

    issue("shl4",   OP_SHL, 1'b0, 16'h0001, 8'd4, 16'h0000, 16'h0010, 16'h0000, 5, 1);
    issue("ror_b",  OP_ROR, 1'b1, 16'h0081, 8'd1, 16'h0000, 16'h00C0, 16'h0001, 2, 1);
    issue("shr0",   OP_SHR, 1'b0, 16'h1234, 8'd0, 16'h0001, 16'h1234, 16'h0001, 1, 1);
`ifdef SHIFT_COUNT_MASK_EN
    issue("shl33",  OP_SHL, 1'b0, 16'h8001, 8'd33, 16'h0000, 16'h0002, 16'h0001, 2, 1);
    issue("shl32",  OP_SHL, 1'b0, 16'h0003, 8'd32, 16'h0001, 16'h0003, 16'h0001, 1, 1);
    issue("shr255", OP_SHR, 1'b0, 16'hFFFF, 8'd255, 16'h0000, 16'h0000, 16'h0000, 32, 1);
`else
    issue("shl33",  OP_SHL, 1'b0, 16'h8001, 8'd33, 16'h0000, 16'h0000, 16'h0000, 34, 1);
    issue("shl32",  OP_SHL, 1'b0, 16'h0003, 8'd32, 16'h0001, 16'h0000, 16'h0000, 33, 1);
    issue("shr255", OP_SHR, 1'b0, 16'hFFFF, 8'd255, 16'h0000, 16'h0000, 16'h0000, 256, 1);
`endif
    issue("sar_b",  OP_SAR, 1'b1, 16'h0080, 8'd2, 16'h0000, 16'h00E0, 16'h0000, 3, 1);
    issue("rol1",   OP_ROL, 1'b0, 16'h8000, 8'd1, 16'h0000, 16'h0001, 16'h0001, 2, 1);
    issue("add_c0", OP_ADD, 1'b0, 16'h0005, 8'd0, 16'h0000, 16'h0005, 16'h0000, 2, 1);
    issue("add_c3", OP_ADD, 1'b0, 16'h0005, 8'd3, 16'h0000, 16'h0008, 16'h0000, 2, 1);
    // start held through RUN and the DONE cycle: only one result may appear.
    issue("rcl8",   OP_RCL, 1'b0, 16'h00FF, 8'd8, 16'h0001, 16'hFF80, 16'h0000, 9, 10);

    @(negedge clk);
    op_in = OP_SHL; is_8_bit_in = 1'b0; operand = 16'h0001; count = 8'd10; flags_in = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_flags", 32'(flags_result), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_alu_flags", 32'(alu_flags_in), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
